// File: rtl/mem_port_arbiter_4x32b.sv
// mem_port_arbiter_4x32b
// Round-robin arbiter sharing one single-ported memory bank between four
// CGRA memory-port requesters. One command per cycle is registered toward the
// bank; read returns are steered back to the issuing port through a tag
// pipeline whose depth matches the bank's fixed read latency (1..8 cycles).
// Optional build macro: MEMARB_PERF_CNT_EN adds per-port saturating grant
// counters with a synchronous clear (ports perf_clr / perf_cnt).
module mem_port_arbiter_4x32b #(
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  CGRA_Clock,
    input  logic                  CGRA_Reset,
    input  logic                  halt,
    input  logic [3:0]            req,
    input  logic [3:0]            we,
    input  logic [4*DATA_W-1:0]   addr_in,
    input  logic [4*DATA_W-1:0]   wdata_in,
    output logic [3:0]            gnt,
    output logic [3:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef MEMARB_PERF_CNT_EN
    ,
    input  logic                  perf_clr,
    output logic [4*16-1:0]       perf_cnt
`endif
);

    logic [1:0] rr_ptr;
    logic [1:0] gnt_idx;
    logic       gnt_any;
    logic [1:0] cand;

    // Port id travelling with the registered command (command stage).
    logic [1:0] cmd_port_p0;

    // Tag pipeline: one entry per cycle of bank read latency.
    logic       tag_vld_p  [MEM_LATENCY];
    logic [1:0] tag_port_p [MEM_LATENCY];

    // Priority search starting at rr_ptr; first requesting port wins.
    always_comb begin
        gnt     = 4'b0000;
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        cand    = 2'd0;
        if (!CGRA_Reset && !halt) begin
            for (int i = 0; i < 4; i++) begin
                cand = rr_ptr + 2'(i);
                if (!gnt_any && req[cand]) begin
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                    gnt_any   = 1'b1;
                end
            end
        end
    end

    // Stage p0: register the accepted command toward the bank and rotate priority.
    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            rr_ptr      <= 2'd0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cmd_port_p0 <= 2'd0;
        end else begin
            mem_en <= gnt_any;
            if (gnt_any) begin
                rr_ptr      <= gnt_idx + 2'd1;
                mem_we      <= we[gnt_idx];
                mem_addr    <= addr_in[int'(gnt_idx)*DATA_W +: DATA_W];
                mem_wdata   <= wdata_in[int'(gnt_idx)*DATA_W +: DATA_W];
                cmd_port_p0 <= gnt_idx;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    // Tag stages: shift read tags so the last stage lines up with mem_rdata.
    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_vld_p[i]  <= 1'b0;
                tag_port_p[i] <= 2'd0;
            end
        end else begin
            tag_vld_p[0]  <= mem_en & ~mem_we;
            tag_port_p[0] <= cmd_port_p0;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_vld_p[i]  <= tag_vld_p[i-1];
                tag_port_p[i] <= tag_port_p[i-1];
            end
        end
    end

    // Return stage: capture bank data only for tracked reads so rdata holds otherwise.
    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            rvalid <= 4'b0000;
            rdata  <= '0;
        end else begin
            if (tag_vld_p[MEM_LATENCY-1]) begin
                rvalid <= 4'b0001 << tag_port_p[MEM_LATENCY-1];
                rdata  <= mem_rdata;
            end else begin
                rvalid <= 4'b0000;
            end
        end
    end

`ifdef MEMARB_PERF_CNT_EN
    logic [15:0] perf_q [4];

    // Per-port grant counters; clear wins over increment, counting stops at all-ones.
    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            for (int k = 0; k < 4; k++) perf_q[k] <= 16'd0;
        end else if (perf_clr) begin
            for (int k = 0; k < 4; k++) perf_q[k] <= 16'd0;
        end else if (gnt_any && perf_q[gnt_idx] != 16'hFFFF) begin
            perf_q[gnt_idx] <= perf_q[gnt_idx] + 16'd1;
        end
    end

    // Pack counters with the same per-port layout as addr_in.
    always_comb begin
        perf_cnt = '0;
        for (int k = 0; k < 4; k++) perf_cnt[k*16 +: 16] = perf_q[k];
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter_4x32b.sv
// Bench for mem_port_arbiter_4x32b: two instances (read latency 1 and 3)
// share one stimulus stream; each has its own bank model and a scoreboard of
// expected read returns built from a reference copy of memory contents.
module tb_mem_port_arbiter_4x32b;

    typedef struct {
        int          due;
        logic [3:0]  port;
        logic [31:0] data;
    } sb_t;

    logic         clk;
    logic         rst;
    logic         halt;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [127:0] addr_in;
    logic [127:0] wdata_in;

    logic [3:0]   gnt_l1, rvalid_l1, gnt_l3, rvalid_l3;
    logic [31:0]  rdata_l1, rdata_l3;
    logic         mem_en_l1, mem_we_l1, mem_en_l3, mem_we_l3;
    logic [31:0]  mem_addr_l1, mem_wdata_l1, mem_rdata_l1;
    logic [31:0]  mem_addr_l3, mem_wdata_l3, mem_rdata_l3;
`ifdef MEMARB_PERF_CNT_EN
    logic         perf_clr;
    logic [63:0]  perf_cnt_l1, perf_cnt_l3;
`endif

    logic [31:0]  arr_l1 [256];
    logic         wr_l1  [256];
    logic [31:0]  arr_l3 [256];
    logic         wr_l3  [256];
    logic [31:0]  ref_mem [256];
    logic         ref_wr  [256];
    logic [31:0]  pipe_l1 [1];
    logic [31:0]  pipe_l3 [3];

    sb_t          q_l1[$];
    sb_t          q_l3[$];
    logic [31:0]  last_l1, last_l3;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    mem_port_arbiter_4x32b #(.DATA_W(32), .MEM_LATENCY(1)) u_dut_l1 (
        .CGRA_Clock(clk), .CGRA_Reset(rst), .halt(halt), .req(req), .we(we),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt_l1), .rvalid(rvalid_l1),
        .rdata(rdata_l1), .mem_en(mem_en_l1), .mem_we(mem_we_l1), .mem_addr(mem_addr_l1),
        .mem_wdata(mem_wdata_l1), .mem_rdata(mem_rdata_l1)
`ifdef MEMARB_PERF_CNT_EN
        , .perf_clr(perf_clr), .perf_cnt(perf_cnt_l1)
`endif
    );

    mem_port_arbiter_4x32b #(.DATA_W(32), .MEM_LATENCY(3)) u_dut_l3 (
        .CGRA_Clock(clk), .CGRA_Reset(rst), .halt(halt), .req(req), .we(we),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt_l3), .rvalid(rvalid_l3),
        .rdata(rdata_l3), .mem_en(mem_en_l3), .mem_we(mem_we_l3), .mem_addr(mem_addr_l3),
        .mem_wdata(mem_wdata_l3), .mem_rdata(mem_rdata_l3)
`ifdef MEMARB_PERF_CNT_EN
        , .perf_clr(perf_clr), .perf_cnt(perf_cnt_l3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            wr_l1[i]  = 1'b0;
            wr_l3[i]  = 1'b0;
            ref_wr[i] = 1'b0;
        end
    end

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return 32'hCAFE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Bank model, latency 1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_l1[0] <= '0;
        end else begin
            if (mem_en_l1 && !mem_we_l1)
                pipe_l1[0] <= wr_l1[mem_addr_l1[7:0]] ? arr_l1[mem_addr_l1[7:0]] : dflt(mem_addr_l1);
            else
                pipe_l1[0] <= 32'hBAD0_BAD0;
            if (mem_en_l1 && mem_we_l1) begin
                arr_l1[mem_addr_l1[7:0]] <= mem_wdata_l1;
                wr_l1[mem_addr_l1[7:0]]  <= 1'b1;
            end
        end
    end
    assign mem_rdata_l1 = pipe_l1[0];

    // Bank model, latency 3.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_l3[0] <= '0;
            pipe_l3[1] <= '0;
            pipe_l3[2] <= '0;
        end else begin
            pipe_l3[2] <= pipe_l3[1];
            pipe_l3[1] <= pipe_l3[0];
            if (mem_en_l3 && !mem_we_l3)
                pipe_l3[0] <= wr_l3[mem_addr_l3[7:0]] ? arr_l3[mem_addr_l3[7:0]] : dflt(mem_addr_l3);
            else
                pipe_l3[0] <= 32'hBAD0_BAD0;
            if (mem_en_l3 && mem_we_l3) begin
                arr_l3[mem_addr_l3[7:0]] <= mem_wdata_l3;
                wr_l3[mem_addr_l3[7:0]]  <= 1'b1;
            end
        end
    end
    assign mem_rdata_l3 = pipe_l3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ret(input int lat, input logic [3:0] rv, input logic [31:0] rd);
        sb_t e;
        logic hit;
        hit = 1'b0;
        e.due = 0; e.port = 4'b0; e.data = 32'h0;
        if (lat == 1) begin
            if (q_l1.size() > 0 && q_l1[0].due == cyc) begin e = q_l1.pop_front(); hit = 1'b1; end
        end else begin
            if (q_l3.size() > 0 && q_l3[0].due == cyc) begin e = q_l3.pop_front(); hit = 1'b1; end
        end
        if (hit) begin
            chk($sformatf("rvalid_L%0d_c%0d", lat, cyc), {28'h0, rv}, {28'h0, e.port});
            chk($sformatf("rdata_L%0d_c%0d", lat, cyc), rd, e.data);
            if (lat == 1) last_l1 = e.data; else last_l3 = e.data;
        end else begin
            chk($sformatf("rvalid_idle_L%0d_c%0d", lat, cyc), {28'h0, rv}, 32'h0);
            chk($sformatf("rdata_hold_L%0d_c%0d", lat, cyc), rd, (lat == 1) ? last_l1 : last_l3);
        end
    endtask

    task automatic accept(input int lat, input logic [3:0] g);
        int k;
        logic [31:0] a;
        sb_t e;
        k = 0;
        for (int i = 0; i < 4; i++) if (g[i]) k = i;
        if (|(req & g)) begin
            a = addr_in[k*32 +: 32];
            if (we[k]) begin
                if (lat == 1) begin
                    ref_mem[a[7:0]] = wdata_in[k*32 +: 32];
                    ref_wr[a[7:0]]  = 1'b1;
                end
            end else begin
                e.due  = cyc + 2 + lat;
                e.port = 4'b0001 << k;
                e.data = ref_wr[a[7:0]] ? ref_mem[a[7:0]] : dflt(a);
                if (lat == 1) q_l1.push_back(e); else q_l3.push_back(e);
            end
        end
    endtask

    // Scoreboard: compare returns due this cycle, then log new acceptances.
    always @(negedge clk) begin
        if (rst) begin
            q_l1.delete();
            q_l3.delete();
            last_l1 = 32'h0;
            last_l3 = 32'h0;
        end else begin
            check_ret(1, rvalid_l1, rdata_l1);
            check_ret(3, rvalid_l3, rdata_l3);
            accept(1, gnt_l1);
            accept(3, gnt_l3);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_port(input int k, input logic [31:0] a, input logic [31:0] d);
        addr_in[k*32 +: 32]  = a;
        wdata_in[k*32 +: 32] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] exp_t5 [3];

    initial begin
        rst = 1'b1; halt = 1'b0; req = 4'hF; we = 4'h0;
        addr_in = '0; wdata_in = '0;
`ifdef MEMARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        // Reset state, with requests present.
        sample();
        chk("rst_gnt", {28'h0, gnt_l1}, 32'h0);
        chk("rst_mem_en", {31'h0, mem_en_l1}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we_l1}, 32'h0);
        chk("rst_mem_addr", mem_addr_l1, 32'h0);
        chk("rst_mem_wdata", mem_wdata_l1, 32'h0);
        chk("rst_rvalid", {28'h0, rvalid_l1}, 32'h0);
        chk("rst_rdata", rdata_l1, 32'h0);
        tick();
        rst = 1'b0; req = 4'h0;
        tick();

        // Single read from port 0.
        set_port(0, 32'h10, 32'h0);
        req = 4'b0001;
        sample(); chk("t1_gnt", {28'h0, gnt_l1}, 32'h1);
        tick(); req = 4'b0000;
        sample();
        chk("t1_mem_en", {31'h0, mem_en_l1}, 32'h1);
        chk("t1_mem_we", {31'h0, mem_we_l1}, 32'h0);
        chk("t1_mem_addr", mem_addr_l1, 32'h10);
        tick(); sample();
        chk("t1_rvalid_c2", {28'h0, rvalid_l1}, 32'h0);
        tick(); sample();
        chk("t1_rvalid_c3", {28'h0, rvalid_l1}, 32'h1);
        chk("t1_rdata_c3", rdata_l1, 32'hCAFE_0010);
        repeat (4) tick();

        // All ports requesting: strict rotation, pipelined reads.
        do_reset();
        for (int k = 0; k < 4; k++) set_port(k, 32'h80 + 32'(4*k), 32'h0);
        req = 4'hF; we = 4'h0;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk($sformatf("t2_gnt_%0d", i), {28'h0, gnt_l1}, 32'(1 << (i % 4)));
            if (i > 0) chk($sformatf("t2_mem_en_%0d", i), {31'h0, mem_en_l1}, 32'h1);
            tick();
        end
        req = 4'h0;
        sample(); chk("t2_mem_en_last", {31'h0, mem_en_l1}, 32'h1);
        repeat (6) tick();

        // Wrap-around from rr_ptr = 2.
        req = 4'b0010;
        sample(); chk("t3_gnt_p1", {28'h0, gnt_l1}, 32'h2);
        tick(); req = 4'b0011;
        sample(); chk("t3_gnt_wrap", {28'h0, gnt_l1}, 32'h1);
        tick(); req = 4'b0011;
        sample(); chk("t3_gnt_after_wrap", {28'h0, gnt_l1}, 32'h2);
        tick(); req = 4'b0000;
        repeat (6) tick();

        // Port 3 write then port 1 read of the same address, latency 3.
        set_port(3, 32'h40, 32'h1234_5678);
        req = 4'b1000; we = 4'b1000;
        sample(); chk("t4_gnt_wr", {28'h0, gnt_l3}, 32'h8);
        tick();
        set_port(1, 32'h40, 32'h0);
        req = 4'b0010; we = 4'b0000;
        sample();
        chk("t4_gnt_rd", {28'h0, gnt_l3}, 32'h2);
        chk("t4_mem_we_1", {31'h0, mem_we_l3}, 32'h1);
        chk("t4_mem_addr", mem_addr_l3, 32'h40);
        chk("t4_mem_wdata", mem_wdata_l3, 32'h1234_5678);
        tick(); req = 4'b0000;
        sample();
        chk("t4_mem_we_0", {31'h0, mem_we_l3}, 32'h0);
        chk("t4_mem_en_rd", {31'h0, mem_en_l3}, 32'h1);
        for (int i = 2; i <= 5; i++) begin
            tick(); sample();
            if (i < 5) chk($sformatf("t4_no_rvalid_%0d", i), {28'h0, rvalid_l3}, 32'h0);
            else begin
                chk("t4_rvalid", {28'h0, rvalid_l3}, 32'h2);
                chk("t4_rdata", rdata_l3, 32'h1234_5678);
            end
        end
        repeat (3) tick();

        // Three reads in flight, then reset mid-flight.
        set_port(0, 32'h50, 32'h0);
        set_port(1, 32'h54, 32'h0);
        set_port(2, 32'h58, 32'h0);
        exp_t5[0] = 4'b0100; exp_t5[1] = 4'b0001; exp_t5[2] = 4'b0010;
        req = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            sample(); chk($sformatf("t5_gnt_%0d", i), {28'h0, gnt_l1}, {28'h0, exp_t5[i]});
            tick();
        end
        req = 4'h0;
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_mem_en", {31'h0, mem_en_l1}, 32'h0);
        chk("t5_rst_mem_we", {31'h0, mem_we_l1}, 32'h0);
        chk("t5_rst_mem_addr", mem_addr_l1, 32'h0);
        chk("t5_rst_rvalid_l1", {28'h0, rvalid_l1}, 32'h0);
        chk("t5_rst_rvalid_l3", {28'h0, rvalid_l3}, 32'h0);
        chk("t5_rst_rdata_l3", rdata_l3, 32'h0);
        req = 4'hF;
        sample(); chk("t5_rst_gnt", {28'h0, gnt_l1}, 32'h0);
        tick();
        rst = 1'b0; req = 4'h0;
        repeat (8) tick();
        req = 4'hF;
        sample(); chk("t5_first_gnt", {28'h0, gnt_l1}, 32'h1);
        tick(); req = 4'h0;
        repeat (6) tick();

        // halt blocks grants while a pending read still returns.
        req = 4'b0010;
        sample(); chk("t6_gnt", {28'h0, gnt_l1}, 32'h2);
        tick();
        halt = 1'b1; req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            sample(); chk($sformatf("t6_halt_gnt_%0d", i), {28'h0, gnt_l3}, 32'h0);
            tick();
        end
        halt = 1'b0; req = 4'h0;
        repeat (3) tick();

`ifdef MEMARB_PERF_CNT_EN
        // Saturating counter and clear.
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        sample();
        for (int k = 0; k < 4; k++) chk($sformatf("pc_clr_%0d", k), {16'h0, perf_cnt_l1[k*16 +: 16]}, 32'h0);
        set_port(2, 32'h20, 32'h0000_A5A5);
        req = 4'b0100; we = 4'b0100;
        repeat (70000) tick();
        sample();
        chk("pc_sat_2", {16'h0, perf_cnt_l1[32 +: 16]}, 32'h0000_FFFF);
        chk("pc_zero_0", {16'h0, perf_cnt_l1[0 +: 16]}, 32'h0);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        sample(); chk("pc_after_clr", {16'h0, perf_cnt_l1[32 +: 16]}, 32'h0);
        tick();
        sample(); chk("pc_incr", {16'h0, perf_cnt_l1[32 +: 16]}, 32'h1);
        req = 4'h0; we = 4'h0;
        repeat (3) tick();
`endif

        chk("sb_drained_l1", 32'(q_l1.size()), 32'h0);
        chk("sb_drained_l3", 32'(q_l3.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
